// File: rtl/clock_controller_if.sv
// ============================================================================
//  Module   : clock_controller_if
//  Purpose  : Control strobes and status bundle for the clock_controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_controller_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       divisorIn;
    logic             loadDivisor;
    logic             run;
    logic             stop;
    logic             step;
    logic             clockOut;
    logic             tick;
    logic             stepDone;
    logic             loadError;
    logic             busy;
    logic [7:0]       divisor;
    logic [CNT_W-1:0] tickCount;

    modport master (
        output divisorIn, loadDivisor, run, stop, step,
        input  clockOut, tick, stepDone, loadError, busy, divisor, tickCount
    );

    modport slave (
        input  divisorIn, loadDivisor, run, stop, step,
        output clockOut, tick, stepDone, loadError, busy, divisor, tickCount
    );
endinterface

`default_nettype wire

// File: rtl/clock_controller.sv
// ============================================================================
//  Module   : clock_controller
//  Purpose  : Programmable integer clock divider with run/stop/single-step.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_controller #(
    parameter logic [7:0] DIV_RESET = 8'd4,
    parameter int         CNT_W     = 16
) (
    input  wire logic           clockIn,
    input  wire logic           resetN,
    clock_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        STEP     = 2'd3
    } state_t;

    localparam logic [7:0] DIV_INIT = (DIV_RESET < 8'd2) ? 8'd2 : DIV_RESET;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       div_q, div_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             step_done_q, step_done_d;
    logic             load_err_q, load_err_d;
    logic [CNT_W-1:0] tick_count_q;

    logic             period_end;
    logic [7:0]       cnt_adv;
    logic [7:0]       div_clamped;

    assign period_end  = (state_q != IDLE) && (cnt_q == div_q - 8'd1);
    assign cnt_adv     = period_end ? 8'd0 : cnt_q + 8'd1;
    assign div_clamped = (bus.divisorIn < 8'd2) ? 8'd2 : bus.divisorIn;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        load_err_d = bus.loadDivisor && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (bus.loadDivisor) begin
                    div_d = div_clamped;
                end
                if (!bus.stop) begin
                    if (bus.run) begin
                        state_d = RUN;
                    end else if (bus.step) begin
                        state_d = STEP;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_adv;
                if (bus.stop) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                cnt_d = cnt_adv;
                if (!bus.stop && bus.run) begin
                    state_d = RUN;
                end else if (period_end) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            STEP: begin
                cnt_d = cnt_adv;
                if (bus.stop) begin
                    state_d = STOPPING;
                end else if (bus.run) begin
                    state_d = RUN;
                end else if (period_end) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops hold the value
    // belonging to the cycle they are visible in.
    always_comb begin
        clk_out_d   = (state_d != IDLE) && (cnt_d >= (div_d >> 1));
        tick_d      = (state_d != IDLE) && (cnt_d == div_d - 8'd1);
        step_done_d = (state_d == STEP) && (cnt_d == div_d - 8'd1);
    end

    always_ff @(posedge clockIn) begin
        if (!resetN) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            div_q        <= DIV_INIT;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            step_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            step_done_q  <= step_done_d;
            load_err_q   <= load_err_d;
            tick_count_q <= tick_count_q + CNT_W'(tick_q);
        end
    end

    assign bus.clockOut  = clk_out_q;
    assign bus.tick      = tick_q;
    assign bus.stepDone  = step_done_q;
    assign bus.loadError = load_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.divisor   = div_q;
    assign bus.tickCount = tick_count_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_controller.sv
// ============================================================================
//  Module   : tb_clock_controller
//  Purpose  : Directed and randomized checks of clock_controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_controller;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    clock_controller_if #(.CNT_W(16)) bus ();

    clock_controller #(
        .DIV_RESET (8'd4),
        .CNT_W     (16)
    ) dut (
        .clockIn (clk),
        .resetN  (rstn),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: mode 0=idle 1=running 2=stopping 3=single step;
    // phase is the position inside the current output period.
    int m_mode  = 0;
    int m_phase = 0;
    int m_div   = 4;
    int m_tc    = 0;
    bit m_tick  = 0;
    bit m_lerr  = 0;

    function automatic int clamp2(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_step();
        bit ending;
        if (!rstn) begin
            m_mode = 0; m_phase = 0; m_div = 4; m_tc = 0; m_tick = 0; m_lerr = 0;
            return;
        end
        if (m_tick) m_tc = (m_tc + 1) % 65536;
        m_lerr = bus.loadDivisor && (m_mode != 0);
        ending = (m_mode != 0) && (m_phase == m_div - 1);
        if (m_mode == 0) begin
            if (bus.loadDivisor) m_div = clamp2(int'(bus.divisorIn));
            m_phase = 0;
            if (!bus.stop) begin
                if (bus.run)       m_mode = 1;
                else if (bus.step) m_mode = 3;
            end
        end else begin
            m_phase = (m_phase + 1) % m_div;
            if (bus.stop) begin
                if (m_mode != 2) m_mode = 2;
                else if (ending) begin m_mode = 0; m_phase = 0; end
            end else if (bus.run) begin
                m_mode = 1;
            end else if (m_mode != 1 && ending) begin
                m_mode = 0; m_phase = 0;
            end
        end
        m_tick = (m_mode != 0) && (m_phase == m_div - 1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        vectors++;
        chk("clockOut",  {31'd0, bus.clockOut},  {31'd0, (m_mode != 0) && (m_phase >= m_div / 2)});
        chk("tick",      {31'd0, bus.tick},      {31'd0, m_tick});
        chk("stepDone",  {31'd0, bus.stepDone},  {31'd0, (m_mode == 3) && m_tick});
        chk("loadError", {31'd0, bus.loadError}, {31'd0, m_lerr});
        chk("busy",      {31'd0, bus.busy},      {31'd0, m_mode != 0});
        chk("divisor",   {24'd0, bus.divisor},   32'(m_div));
        chk("tickCount", {16'd0, bus.tickCount}, 32'(m_tc));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        bus.run = 0; bus.stop = 0; bus.step = 0; bus.loadDivisor = 0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wait_phase(input int p);
        for (int k = 0; k < 300 && !(m_mode != 0 && m_phase == p); k++) cycle();
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && m_mode != 0; k++) cycle();
    endtask

    initial begin
        bus.divisorIn = 8'd0; bus.loadDivisor = 0;
        bus.run = 0; bus.stop = 0; bus.step = 0;

        // Reset state
        rstn = 0; cycles(3); rstn = 1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_div",  {24'd0, bus.divisor}, 32'd4);
        chk("rst_tc",   {16'd0, bus.tickCount}, 32'd0);

        // Free run with divisor 4, then stop at cnt=1
        bus.run = 1; cycle();
        cycles(11);
        wait_phase(1);
        bus.stop = 1; cycle();
        chk("stop_busy_cnt2", {31'd0, bus.busy}, 32'd1);
        cycle();
        chk("stop_tick", {31'd0, bus.tick}, 32'd1);
        cycle();
        chk("stop_idle", {31'd0, bus.busy}, 32'd0);
        chk("stop_clkout", {31'd0, bus.clockOut}, 32'd0);

        // Divisor 5 loaded together with run
        bus.divisorIn = 8'd5; bus.loadDivisor = 1; bus.run = 1; cycle();
        cycles(15);
        bus.stop = 1; cycle();
        drain(); cycle();

        // Single step with divisor 4
        bus.divisorIn = 8'd4; bus.loadDivisor = 1; cycle();
        bus.step = 1; cycle();
        cycles(2);
        cycle();
        chk("step_done", {31'd0, bus.stepDone}, 32'd1);
        cycle();
        chk("step_busy", {31'd0, bus.busy}, 32'd0);
        cycles(2);

        // Load rejected while running, then load of 0 in idle
        bus.run = 1; cycle();
        cycles(2);
        bus.divisorIn = 8'd6; bus.loadDivisor = 1; cycle();
        chk("lerr_pulse", {31'd0, bus.loadError}, 32'd1);
        chk("lerr_div",   {24'd0, bus.divisor}, 32'd4);
        cycle();
        bus.stop = 1; cycle();
        drain();
        bus.divisorIn = 8'd0; bus.loadDivisor = 1; cycle();
        chk("load0_div", {24'd0, bus.divisor}, 32'd2);

        // Reset mid-run at cnt=2
        bus.divisorIn = 8'd4; bus.loadDivisor = 1; bus.run = 1; cycle();
        cycles(5);
        wait_phase(2);
        rstn = 0; cycle(); rstn = 1;
        chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst_clk",  {31'd0, bus.clockOut}, 32'd0);
        chk("mrst_tc",   {16'd0, bus.tickCount}, 32'd0);
        chk("mrst_tick", {31'd0, bus.tick}, 32'd0);
        cycles(2);

        // Randomized strobes
        for (int i = 0; i < 1500; i++) begin
            bus.divisorIn   = 8'($urandom_range(0, 9));
            bus.loadDivisor = ($urandom_range(0, 7) == 0);
            bus.run         = ($urandom_range(0, 5) == 0);
            bus.stop        = ($urandom_range(0, 9) == 0);
            bus.step        = ($urandom_range(0, 7) == 0);
            rstn            = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rstn = 1;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
